// File: rtl/pixel_scheduler_if.sv
// Handshake bundle between the pixel scheduler, its iterator cores and the result sink.
//   core_ready  : per-core idle/accept indication (env -> scheduler)
//   core_start  : one-hot dispatch strobe; core_x/core_y carry the pixel
//   core_done   : per-core result available, held until core_ack
//   core_result : per-core iteration counts, core i at [i*ITER_BITS +: ITER_BITS]
//   core_ack    : one-hot result-accepted strobe
//   out_*       : registered result slot with valid/ready back-pressure
// The master modport is the scheduler side; slave is the cores/sink side.
interface pixel_scheduler_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned X_BITS    = 10,
    parameter int unsigned Y_BITS    = 9,
    parameter int unsigned ITER_BITS = 8
);
    logic [NUM_CORES-1:0]           core_ready;
    logic [NUM_CORES-1:0]           core_start;
    logic [X_BITS-1:0]              core_x;
    logic [Y_BITS-1:0]              core_y;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES*ITER_BITS-1:0] core_result;
    logic [NUM_CORES-1:0]           core_ack;
    logic                           out_valid;
    logic                           out_ready;
    logic [X_BITS-1:0]              out_x;
    logic [Y_BITS-1:0]              out_y;
    logic [ITER_BITS-1:0]           out_iter;

    modport master (
        input  core_ready, core_done, core_result, out_ready,
        output core_start, core_x, core_y, core_ack, out_valid, out_x, out_y, out_iter
    );

    modport slave (
        output core_ready, core_done, core_result, out_ready,
        input  core_start, core_x, core_y, core_ack, out_valid, out_x, out_y, out_iter
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Frame-level work scheduler: raster-scans a WIDTH x HEIGHT frame, dispatches one pixel per
// cycle round-robin to idle iterator cores, and collects results round-robin into a single
// registered valid/ready output slot.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : frame start request, honoured only when idle
//   busy       : high while dispatching or draining
//   frame_done : one-cycle pulse once the last result has been consumed
//   sched      : core dispatch/collect and result-output bundle (master side)
// All outputs are registered.
module pixel_scheduler #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned X_BITS    = 10,
    parameter int unsigned Y_BITS    = 9,
    parameter int unsigned ITER_BITS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    pixel_scheduler_if.master  sched
);
    localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [X_BITS-1:0]    cur_x_q, cur_x_d;
    logic [Y_BITS-1:0]    cur_y_q, cur_y_d;
    logic [PtrW-1:0]      dp_q, dp_d;
    logic [PtrW-1:0]      cp_q, cp_d;
    logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
    logic [X_BITS-1:0]    coord_x_q [NUM_CORES];
    logic [Y_BITS-1:0]    coord_y_q [NUM_CORES];

    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic [X_BITS-1:0]    core_x_q, core_x_d;
    logic [Y_BITS-1:0]    core_y_q, core_y_d;
    logic [NUM_CORES-1:0] core_ack_q, core_ack_d;
    logic                 out_valid_q, out_valid_d;
    logic [X_BITS-1:0]    out_x_q, out_x_d;
    logic [Y_BITS-1:0]    out_y_q, out_y_d;
    logic [ITER_BITS-1:0] out_iter_q, out_iter_d;

    logic [NUM_CORES-1:0] eligible, cand;
    logic                 disp_en, col_en, slot_free, last_pixel;
    logic [PtrW-1:0]      disp_idx, col_idx;
    logic [X_BITS-1:0]    sel_x;
    logic [Y_BITS-1:0]    sel_y;
    logic [ITER_BITS-1:0] sel_iter;

    // First requester at or after ptr, wrapping.
    function automatic logic [PtrW-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                input logic [PtrW-1:0]      ptr);
        logic [PtrW-1:0]      pick;
        logic                 found;
        logic [NUM_CORES-1:0] rot;
        int unsigned          k;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            k   = (32'(ptr) + i) % NUM_CORES;
            rot = req >> k;
            if (!found && rot[0]) begin
                found = 1'b1;
                pick  = PtrW'(k);
            end
        end
        return pick;
    endfunction

    // Dispatch / collection decisions, all from registered state.
    always_comb begin
        eligible   = sched.core_ready & ~core_busy_q;
        // A done from a core we never dispatched to is ignored.
        cand       = sched.core_done & core_busy_q;
        slot_free  = !out_valid_q || sched.out_ready;
        disp_en    = (state_q == StRun) && (|eligible);
        col_en     = ((state_q == StRun) || (state_q == StDrain)) && slot_free && (|cand);
        disp_idx   = rr_pick(eligible, dp_q);
        col_idx    = rr_pick(cand, cp_q);
        last_pixel = (cur_x_q == X_BITS'(WIDTH - 1)) && (cur_y_q == Y_BITS'(HEIGHT - 1));
        sel_x      = '0;
        sel_y      = '0;
        sel_iter   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (col_idx == PtrW'(i)) begin
                sel_x    = coord_x_q[i];
                sel_y    = coord_y_q[i];
                sel_iter = sched.core_result[i*ITER_BITS +: ITER_BITS];
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (disp_en && last_pixel) state_d = StDrain;
            // With no busy cores nothing can reload the slot, so a consuming slot is empty next.
            StDrain: if ((core_busy_q == '0) && slot_free) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath next state.
    always_comb begin
        busy_d       = (state_d == StRun) || (state_d == StDrain);
        frame_done_d = (state_d == StDone);
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        dp_d         = dp_q;
        cp_d         = cp_q;
        core_busy_d  = core_busy_q;
        core_start_d = '0;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_ack_d   = '0;
        out_valid_d  = out_valid_q && !sched.out_ready;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_iter_d   = out_iter_q;

        if ((state_q == StIdle) && start) begin
            cur_x_d = '0;
            cur_y_d = '0;
        end

        if (disp_en) begin
            core_start_d = NUM_CORES'(1) << disp_idx;
            core_x_d     = cur_x_q;
            core_y_d     = cur_y_q;
            core_busy_d  = core_busy_d | (NUM_CORES'(1) << disp_idx);
            dp_d         = (disp_idx == PtrW'(NUM_CORES - 1)) ? '0 : disp_idx + 1'b1;
            if (cur_x_q == X_BITS'(WIDTH - 1)) begin
                cur_x_d = '0;
                cur_y_d = cur_y_q + 1'b1;
            end else begin
                cur_x_d = cur_x_q + 1'b1;
            end
        end

        // Collection only targets busy cores and dispatch only idle ones, so the two
        // busy-mask updates never touch the same bit.
        if (col_en) begin
            out_valid_d = 1'b1;
            out_x_d     = sel_x;
            out_y_d     = sel_y;
            out_iter_d  = sel_iter;
            core_ack_d  = NUM_CORES'(1) << col_idx;
            core_busy_d = core_busy_d & ~(NUM_CORES'(1) << col_idx);
            cp_d        = (col_idx == PtrW'(NUM_CORES - 1)) ? '0 : col_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            dp_q         <= '0;
            cp_q         <= '0;
            core_busy_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            core_start_q <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_ack_q   <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_iter_q   <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                coord_x_q[i] <= '0;
                coord_y_q[i] <= '0;
            end
        end else begin
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            dp_q         <= dp_d;
            cp_q         <= cp_d;
            core_busy_q  <= core_busy_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            core_start_q <= core_start_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_ack_q   <= core_ack_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_iter_q   <= out_iter_d;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (disp_en && (disp_idx == PtrW'(i))) begin
                    coord_x_q[i] <= cur_x_q;
                    coord_y_q[i] <= cur_y_q;
                end
            end
        end
    end

    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign sched.core_start = core_start_q;
    assign sched.core_x     = core_x_q;
    assign sched.core_y     = core_y_q;
    assign sched.core_ack   = core_ack_q;
    assign sched.out_valid  = out_valid_q;
    assign sched.out_x      = out_x_q;
    assign sched.out_y      = out_y_q;
    assign sched.out_iter   = out_iter_q;
endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler on a 4x2 frame with two modelled iterator cores (result = x+y).
// Expected pixels are queued when a frame is started and retired as the DUT emits them.
module tb_pixel_scheduler;
    localparam int NC = 2;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XB = 3;
    localparam int YB = 2;
    localparam int IB = 8;

    typedef struct packed {
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [IB-1:0] it;
    } px_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    pixel_scheduler_if #(.NUM_CORES(NC), .X_BITS(XB), .Y_BITS(YB), .ITER_BITS(IB)) bus ();

    pixel_scheduler #(
        .NUM_CORES(NC), .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB), .ITER_BITS(IB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy(busy),
        .frame_done(frame_done),
        .sched(bus)
    );

    always #5 clock = ~clock;

    // Core model state
    logic [NC-1:0]    cready = '1;
    logic [NC-1:0]    cdone  = '0;
    logic [NC*IB-1:0] cres   = '0;
    int               has_job [NC];
    int               cnt [NC];
    int               jx [NC];
    int               jy [NC];
    int               lat [NC];

    assign bus.core_ready  = cready;
    assign bus.core_done   = cdone;
    assign bus.core_result = cres;

    // Scoreboard and counters
    px_t           sb[$];
    logic [NC-1:0] ack_log[$];
    int            checks = 0;
    int            failures = 0;
    int            out_count = 0, out_base = 0;
    int            done_count = 0, done_base = 0;
    int            disp_cnt = 0, disp_base = 0;
    bit            rr_on = 1'b0;
    logic [NC-1:0] rr_exp = 2'b01;
    bit            stall_prev = 1'b0;
    bit            prev_busy = 1'b0;
    logic [XB-1:0] sx;
    logic [YB-1:0] sy;
    logic [IB-1:0] si;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic begin_frame();
        px_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.x  = XB'(x);
                e.y  = YB'(y);
                e.it = IB'(x + y);
                sb.push_back(e);
            end
        end
        out_base  = out_count;
        done_base = done_count;
        disp_base = disp_cnt;
        ack_log.delete();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 400; n++) begin
            if (done_count != done_base) break;
            cyc();
        end
        check("frame_done_seen", 32'(done_count != done_base), 1);
        repeat (3) cyc();
        check("frame_done_once", done_count - done_base, 1);
        check("out_count", out_count - out_base, W * H);
        check("dispatch_count", disp_cnt - disp_base, W * H);
        check("scoreboard_empty", sb.size(), 0);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_core_start"}, bus.core_start, 0);
        check({pfx, "_core_x"}, bus.core_x, 0);
        check({pfx, "_core_y"}, bus.core_y, 0);
        check({pfx, "_core_ack"}, bus.core_ack, 0);
        check({pfx, "_out_valid"}, bus.out_valid, 0);
        check({pfx, "_out_x"}, bus.out_x, 0);
        check({pfx, "_out_y"}, bus.out_y, 0);
        check({pfx, "_out_iter"}, bus.out_iter, 0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            has_job[i] = 0;
            cnt[i]     = 0;
            jx[i]      = 0;
            jy[i]      = 0;
            lat[i]     = 3;
        end

        // Monitor and core model, sampled on the falling edge.
        fork
            forever begin
                @(negedge clock);
                if (!reset) begin
                    for (int i = 0; i < NC; i++) has_job[i] = 0;
                    cdone      = '0;
                    cready     = '1;
                    stall_prev = 1'b0;
                    prev_busy  = 1'b0;
                end else begin
                    if (bus.core_start != '0) begin
                        check("dispatch_onehot", 32'($onehot(bus.core_start)), 1);
                        check("dispatch_x", bus.core_x, (disp_cnt - disp_base) % W);
                        check("dispatch_y", bus.core_y, (disp_cnt - disp_base) / W);
                        if (rr_on) begin
                            check("rr_grant", bus.core_start, rr_exp);
                            rr_exp = {rr_exp[0], rr_exp[1]};
                        end
                        disp_cnt++;
                    end
                    if (bus.core_ack != '0) begin
                        check("ack_onehot", 32'($onehot(bus.core_ack)), 1);
                        ack_log.push_back(bus.core_ack);
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        bit found;
                        found = 1'b0;
                        out_count++;
                        for (int k = 0; k < sb.size(); k++) begin
                            if (!found && sb[k].x == bus.out_x && sb[k].y == bus.out_y) begin
                                check("out_iter", bus.out_iter, sb[k].it);
                                sb.delete(k);
                                found = 1'b1;
                            end
                        end
                        check("out_expected_pixel", 32'(found), 1);
                        stall_prev = 1'b0;
                    end else if (bus.out_valid) begin
                        if (stall_prev) begin
                            check("stall_x_stable", bus.out_x, sx);
                            check("stall_y_stable", bus.out_y, sy);
                            check("stall_iter_stable", bus.out_iter, si);
                            check("stall_no_ack", bus.core_ack, 0);
                        end
                        sx = bus.out_x;
                        sy = bus.out_y;
                        si = bus.out_iter;
                        stall_prev = 1'b1;
                    end else begin
                        stall_prev = 1'b0;
                    end
                    if (frame_done) begin
                        done_count++;
                        check("done_busy_low", busy, 0);
                        check("busy_before_done", 32'(prev_busy), 1);
                    end
                    prev_busy = busy;

                    for (int i = 0; i < NC; i++) begin
                        if (cdone[i] && bus.core_ack[i]) begin
                            cdone[i]   = 1'b0;
                            has_job[i] = 0;
                            cready[i]  = 1'b1;
                        end else if (has_job[i] != 0 && !cdone[i]) begin
                            cnt[i]--;
                            if (cnt[i] == 0) begin
                                cdone[i] = 1'b1;
                                cres[i*IB +: IB] = IB'(jx[i] + jy[i]);
                            end
                        end
                        if (bus.core_start[i]) begin
                            has_job[i] = 1;
                            cready[i]  = 1'b0;
                            jx[i]      = int'(bus.core_x);
                            jy[i]      = int'(bus.core_y);
                            cnt[i]     = lat[i];
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) cyc();
        check_all_zero("reset");
        reset = 1'b1;
        cyc();

        // Round-robin dispatch with single-cycle cores
        lat[0] = 1;
        lat[1] = 1;
        rr_exp = 2'b01;
        rr_on  = 1'b1;
        begin_frame();
        wait_frame();
        rr_on = 1'b0;

        // Basic frame, 3-cycle cores
        lat[0] = 3;
        lat[1] = 3;
        begin_frame();
        wait_frame();

        // Reset mid-frame: outputs clear without a clock edge, no frame_done
        begin_frame();
        repeat (5) cyc();
        check("midframe_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        repeat (3) cyc();
        check("no_done_after_reset", done_count - done_base, 0);
        reset = 1'b1;
        cyc();

        // Simultaneous done right after reset (collect pointer 0): core 0 first
        lat[0] = 2;
        lat[1] = 1;
        begin_frame();
        wait_frame();
        check("ack_log_size", ack_log.size(), W * H);
        if (ack_log.size() >= 2) begin
            check("simul_first_ack", ack_log[0], 2'b01);
            check("simul_second_ack", ack_log[1], 2'b10);
        end

        // Back-pressure mid-frame
        lat[0] = 3;
        lat[1] = 3;
        begin_frame();
        for (int n = 0; n < 200; n++) begin
            if (out_count - out_base >= 2) break;
            cyc();
        end
        check("bp_two_outputs", 32'(out_count - out_base >= 2), 1);
        bus.out_ready = 1'b0;
        repeat (20) cyc();
        check("bp_valid_held", bus.out_valid, 1);
        check("bp_no_ack", bus.core_ack, 0);
        bus.out_ready = 1'b1;
        wait_frame();

        // start while busy is ignored, then a second frame from idle
        begin_frame();
        for (int n = 0; n < 4; n++) begin
            start = 1'b1;
            cyc();
            start = 1'b0;
            cyc();
        end
        wait_frame();
        begin_frame();
        wait_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Frame-level work scheduler for the fractal renderer.
- Raster-scans a WIDTH x HEIGHT frame and dispatches pixel coordinates to NUM_CORES pixel_iterator cores, one dispatch per cycle, round-robin among idle cores.
- Collects finished iteration counts through a single registered output port with valid/ready back-pressure.
- Sits between frame control (start/done) and the iterator array; output feeds the colour/framebuffer writer.

Parameters:
NUM_CORES, 2, number of iterator cores served (>=1)
WIDTH, 640, pixels per row (>=1)
HEIGHT, 480, rows per frame (>=1)
X_BITS, 10, coordinate width for x (2^X_BITS >= WIDTH)
Y_BITS, 9, coordinate width for y (2^Y_BITS >= HEIGHT)
ITER_BITS, 8, iteration-count width returned by cores

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  frame start request; honoured only in IDLE
busy  output  1  high in RUN and DRAIN
frame_done  output  1  one-cycle pulse when the last result has been consumed
core_ready  input  NUM_CORES  per-core idle/accept indication
core_start  output  NUM_CORES  one-hot, one-cycle dispatch strobe
core_x  output  X_BITS  dispatched x, valid while core_start != 0
core_y  output  Y_BITS  dispatched y, valid while core_start != 0
core_done  input  NUM_CORES  per-core result available; held until core_ack
core_result  input  NUM_CORES*ITER_BITS  per-core iteration count; core i at [i*ITER_BITS +: ITER_BITS]
core_ack  output  NUM_CORES  one-hot, one-cycle result-accepted strobe
out_valid  output  1  result slot full
out_ready  input  1  downstream accepts; transfer when out_valid & out_ready
out_x  output  X_BITS  result pixel x
out_y  output  Y_BITS  result pixel y
out_iter  output  ITER_BITS  result iteration count

Behaviour:
- Reset (async, reset=0):
  - State IDLE; cursor (0,0); both round-robin pointers 0; core_busy mask 0; per-core coordinate registers 0.
  - All outputs 0.
  - Reset mid-frame abandons all work; no frame_done is generated.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN; cursor set to (0,0).
  - RUN: dispatch. When pixel (WIDTH-1, HEIGHT-1) is dispatched -> DRAIN.
  - DRAIN: -> DONE when core_busy == 0 and the output slot is empty, or is being consumed that cycle with no reload.
  - DONE: frame_done=1 for one cycle -> IDLE.
  - start is ignored outside IDLE.
- Dispatch (RUN only):
  - Eligible cores are core_ready[i] & ~core_busy[i], using the registered core_busy.
  - Grant the first eligible core at or after dispatch pointer p, wrapping.
  - Next cycle: core_start = one-hot grant, core_x/core_y = cursor. Latch cursor into coord[i]; set core_busy[i]; p = grant+1 mod NUM_CORES.
  - Cursor increments x; at x == WIDTH-1, x wraps to 0 and y increments.
  - At most one dispatch per cycle. core_x/core_y hold their last value when idle.
  - Latency: start sampled at edge E0; first core_start is visible after edge E1.
- Collection (RUN, DRAIN):
  - Candidates are core_done[i] & core_busy[i]; core_done on a non-busy core is ignored.
  - The slot can load when out_valid == 0, or when out_valid & out_ready in the same cycle.
  - On load: grant round-robin from collect pointer q. Next cycle: out_valid=1, out_x/out_y = coord[grant], out_iter = core_result slice, core_ack one-hot pulse. Clear core_busy[grant]; q = grant+1.
  - At most one collection per cycle. Simultaneous dones are served on successive loads in round-robin order.
  - A core that is acked at edge E may be dispatched again from edge E+1 onward. It is never re-dispatched on the same edge as its ack.
- Back-pressure:
  - While out_valid=1 and out_ready=0, out_* stay stable and no core_ack is issued.
  - Dispatch continues to other idle cores.
- Ordering:
  - Results are not in raster order.
  - Every pixel of the frame appears on the output exactly once per frame.
- Degenerate frames:
  - WIDTH=HEIGHT=1: a single dispatch, RUN -> DRAIN immediately.
  - NUM_CORES=1: pointers stay 0.

Test Plan:
- Basic frame: NUM_CORES=2, WIDTH=4, HEIGHT=2; core model = 3-cycle latency, result = x+y; out_ready=1; pulse start -> exactly 8 outputs, each (x,y) in {0..3}x{0..1} exactly once with out_iter=x+y; one frame_done pulse; busy falls in the same cycle.
- Round-robin dispatch: both cores always ready, done 1 cycle after start -> core_start sequence 01,10,01,10...; coordinates (0,0),(1,0),(2,0),(3,0),(0,1)...
- Back-pressure: out_ready=0 for 20 cycles mid-frame -> out_valid stays 1 with out_x/out_y/out_iter constant; no core_ack during the stall; after release, all 8 pixels still delivered with no duplicates.
- Simultaneous done: both cores raise core_done in the same cycle with q=0 -> core 0 acked first and core 1 on the next load; both results present.
- Reset mid-frame: drive reset=0 during RUN -> all outputs 0 immediately (asynchronous, no clock edge needed); release, then start -> full frame from (0,0); exactly one frame_done.
- start while busy: pulse start repeatedly during RUN/DRAIN -> ignored; the frame completes with one frame_done; a start in IDLE afterwards runs a second full frame.
